// File: rtl/memory_stage.sv
// memory_stage: data-cache access FSM with load extension, store lane steering and writeback register
module memory_stage #(
   parameter int DATA_WIDTH      = 32,
   parameter int READ_DATA_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       valid_m,
   input  logic [DATA_WIDTH-1:0]      PCPlus4_m,
   input  logic [DATA_WIDTH-1:0]      ALUResult_m,
   input  logic [DATA_WIDTH-1:0]      WriteData_m,
   input  logic [READ_DATA_WIDTH-1:0] Rd_m,
   input  logic                       RegWrite_m,
   input  logic [1:0]                 ResultSrc_m,
   input  logic                       MemWrite_m,
   input  logic [2:0]                 MemCtrl_m,
   output logic                       dc_req,
   output logic                       dc_we,
   output logic [DATA_WIDTH-1:0]      dc_addr,
   output logic [DATA_WIDTH-1:0]      dc_wdata,
   output logic [3:0]                 dc_be,
   input  logic                       dc_ack,
   input  logic [DATA_WIDTH-1:0]      dc_rdata,
   output logic                       stall_m,
   output logic                       valid_w,
   output logic [DATA_WIDTH-1:0]      PCPlus4_w,
   output logic [DATA_WIDTH-1:0]      ALUResult_w,
   output logic [DATA_WIDTH-1:0]      ReadData_w,
   output logic [READ_DATA_WIDTH-1:0] Rd_w,
   output logic                       RegWrite_w,
   output logic [1:0]                 ResultSrc_w
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, next;
   logic access, store;
   logic [DATA_WIDTH-1:0] hold, shifted, ld;
   logic [7:0] lb;
   logic [15:0] lh;
   assign access  = valid_m & (ResultSrc_m == 2'b01 | MemWrite_m);
   assign store   = valid_m & MemWrite_m;
   assign stall_m = access & (state != DONE);
   assign dc_req  = state == BUSY;
   assign dc_we   = store;
   assign dc_addr = {ALUResult_m[DATA_WIDTH-1:2], 2'b00};
   assign dc_be   = !store ? 4'b0000 :
                    MemCtrl_m[1:0] == 2'b00 ? 4'b0001 << ALUResult_m[1:0] :
                    MemCtrl_m[1:0] == 2'b01 ? 4'b0011 << {ALUResult_m[1], 1'b0} : 4'b1111;
   assign dc_wdata = MemCtrl_m[1:0] == 2'b00 ? {4{WriteData_m[7:0]}} :
                     MemCtrl_m[1:0] == 2'b01 ? {2{WriteData_m[15:0]}} : WriteData_m;
   assign shifted = dc_rdata >> {ALUResult_m[1:0], 3'b000};
   assign lb      = shifted[7:0];
   assign lh      = ALUResult_m[1] ? dc_rdata[31:16] : dc_rdata[15:0];
   assign ld      = MemCtrl_m == 3'b000 ? {{24{lb[7]}}, lb} :
                    MemCtrl_m == 3'b001 ? {{16{lh[15]}}, lh} :
                    MemCtrl_m == 3'b100 ? {24'b0, lb} :
                    MemCtrl_m == 3'b101 ? {16'b0, lh} : dc_rdata;
   always_comb begin
      next = state;
      next = state == IDLE ? (access ? BUSY : IDLE) :
             state == BUSY ? (dc_ack ? DONE : BUSY) : (en ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hold  <= '0;
      end else begin
         state <= next;
         if (state == BUSY && dc_ack) hold <= MemWrite_m ? '0 : ld;
      end
   end
   // stall_m already covers every access not yet in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_w     <= 1'b0;
         PCPlus4_w   <= '0;
         ALUResult_w <= '0;
         ReadData_w  <= '0;
         Rd_w        <= '0;
         RegWrite_w  <= 1'b0;
         ResultSrc_w <= '0;
      end else if (en && !stall_m) begin
         valid_w     <= valid_m;
         PCPlus4_w   <= PCPlus4_m;
         ALUResult_w <= ALUResult_m;
         ReadData_w  <= access ? hold : '0;
         Rd_w        <= Rd_m;
         RegWrite_w  <= valid_m & RegWrite_m;
         ResultSrc_w <= ResultSrc_m;
      end
   end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors for memory_stage
module tb_memory_stage;
   logic clk = 0, rst_n = 0, en = 0, valid_m = 0;
   logic [31:0] PCPlus4_m = 0, ALUResult_m = 0, WriteData_m = 0;
   logic [4:0] Rd_m = 0;
   logic RegWrite_m = 0, MemWrite_m = 0;
   logic [1:0] ResultSrc_m = 0;
   logic [2:0] MemCtrl_m = 0;
   logic dc_req, dc_we, dc_ack = 0, stall_m;
   logic [31:0] dc_addr, dc_wdata, dc_rdata = 0;
   logic [3:0] dc_be;
   logic valid_w, RegWrite_w;
   logic [31:0] PCPlus4_w, ALUResult_w, ReadData_w;
   logic [4:0] Rd_w;
   logic [1:0] ResultSrc_w;
   int total = 0, bad = 0;
   memory_stage dut (
      .clk(clk), .rst_n(rst_n), .en(en), .valid_m(valid_m), .PCPlus4_m(PCPlus4_m),
      .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m), .Rd_m(Rd_m),
      .RegWrite_m(RegWrite_m), .ResultSrc_m(ResultSrc_m), .MemWrite_m(MemWrite_m),
      .MemCtrl_m(MemCtrl_m), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
      .dc_wdata(dc_wdata), .dc_be(dc_be), .dc_ack(dc_ack), .dc_rdata(dc_rdata),
      .stall_m(stall_m), .valid_w(valid_w), .PCPlus4_w(PCPlus4_w),
      .ALUResult_w(ALUResult_w), .ReadData_w(ReadData_w), .Rd_w(Rd_w),
      .RegWrite_w(RegWrite_w), .ResultSrc_w(ResultSrc_w)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_op(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wd,
                         input logic st, input logic [4:0] rd);
      valid_m = 1; MemCtrl_m = ctrl; ALUResult_m = addr; WriteData_m = wd;
      MemWrite_m = st; ResultSrc_m = st ? 2'b00 : 2'b01; RegWrite_m = !st; Rd_m = rd;
      PCPlus4_m = addr + 4;
   endtask
   // leaves the stage in DONE; caller decides when en releases it
   task automatic run_to_done(input logic [31:0] rdata, input int delay);
      #1;
      step();
      repeat (delay) begin
         chk("busy_req", dc_req, 1);
         step();
      end
      dc_ack = 1; dc_rdata = rdata;
      step();
      dc_ack = 0;
   endtask
   initial begin
      #1;
      chk("rst_req", dc_req, 0);
      chk("rst_valid_w", valid_w, 0);
      chk("rst_readdata", ReadData_w, 0);
      step();
      rst_n = 1; en = 1;
      // LW
      set_op(3'b010, 32'h100, 0, 0, 5'd3);
      #1;
      chk("lw_stall_idle", stall_m, 1);
      chk("lw_addr", dc_addr, 32'h100);
      chk("lw_be", dc_be, 0);
      step();
      chk("lw_req", dc_req, 1);
      chk("lw_stall_busy", stall_m, 1);
      dc_ack = 1; dc_rdata = 32'hDEADBEEF;
      step();
      dc_ack = 0;
      chk("lw_stall_done", stall_m, 0);
      chk("lw_req_done", dc_req, 0);
      chk("lw_not_yet", ReadData_w, 0);
      step();
      chk("lw_data", ReadData_w, 32'hDEADBEEF);
      chk("lw_valid_w", valid_w, 1);
      chk("lw_rd", Rd_w, 3);
      // LB / LBU
      set_op(3'b000, 32'h103, 0, 0, 5'd4);
      run_to_done(32'h80112233, 0);
      step();
      chk("lb_data", ReadData_w, 32'hFFFFFF80);
      set_op(3'b100, 32'h103, 0, 0, 5'd4);
      run_to_done(32'h80112233, 0);
      step();
      chk("lbu_data", ReadData_w, 32'h00000080);
      set_op(3'b001, 32'h102, 0, 0, 5'd4);
      run_to_done(32'h8001F234, 0);
      step();
      chk("lh_data", ReadData_w, 32'hFFFF8001);
      // SH
      set_op(3'b001, 32'h102, 32'h0000ABCD, 1, 5'd0);
      #1;
      chk("sh_we", dc_we, 1);
      chk("sh_be", dc_be, 4'b1100);
      chk("sh_wdata", dc_wdata, 32'hABCDABCD);
      chk("sh_addr", dc_addr, 32'h100);
      run_to_done(32'h55555555, 0);
      step();
      chk("sh_readdata", ReadData_w, 0);
      set_op(3'b000, 32'h101, 32'h000000A5, 1, 5'd0);
      #1;
      chk("sb_be", dc_be, 4'b0010);
      chk("sb_wdata", dc_wdata, 32'hA5A5A5A5);
      run_to_done(0, 0);
      step();
      // delayed ack, en low in DONE
      set_op(3'b010, 32'h200, 0, 0, 5'd9);
      run_to_done(32'h12345678, 4);
      en = 0;
      #1;
      chk("dly_stall_done", stall_m, 0);
      step();
      step();
      chk("dly_held_data", ReadData_w, 0);
      chk("dly_held_rd", Rd_w, 0);
      chk("dly_stall_hold", stall_m, 0);
      en = 1;
      step();
      chk("dly_data", ReadData_w, 32'h12345678);
      chk("dly_rd", Rd_w, 9);
      // reset asserted in BUSY
      set_op(3'b010, 32'h300, 0, 0, 5'd5);
      #1;
      step();
      chk("rb_req", dc_req, 1);
      #2 rst_n = 0;
      #1;
      chk("rb_req_async", dc_req, 0);
      chk("rb_valid_async", valid_w, 0);
      valid_m = 0;
      step();
      rst_n = 1;
      dc_ack = 1; dc_rdata = 32'hBADBAD00;
      step();
      dc_ack = 0;
      chk("rb_ack_ignored_req", dc_req, 0);
      chk("rb_ack_ignored_data", ReadData_w, 0);
      chk("rb_valid_w", valid_w, 0);
      set_op(3'b010, 32'h304, 0, 0, 5'd6);
      #1;
      chk("rb_idle_stall", stall_m, 1);
      step();
      chk("rb_idle_to_busy", dc_req, 1);
      dc_ack = 1; dc_rdata = 32'hCAFEF00D;
      step();
      dc_ack = 0;
      step();
      chk("rb_after_data", ReadData_w, 32'hCAFEF00D);
      // ALU op then bubble
      valid_m = 1; RegWrite_m = 1; Rd_m = 7; ALUResult_m = 5; ResultSrc_m = 0; MemWrite_m = 0;
      MemCtrl_m = 3'b010;
      #1;
      chk("alu_stall", stall_m, 0);
      step();
      chk("alu_valid_w", valid_w, 1);
      chk("alu_rd", Rd_w, 7);
      chk("alu_result", ALUResult_w, 5);
      chk("alu_regwrite", RegWrite_w, 1);
      chk("alu_readdata", ReadData_w, 0);
      valid_m = 0;
      step();
      chk("bub_valid_w", valid_w, 0);
      chk("bub_regwrite", RegWrite_w, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
